stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Packet-granular round-robin arbiter that merges PORT_NUM axis-like request streams (tuser/tdata/tstart/tlast) onto one output stream feeding a stream FIFO input. A grant is held from the first accepted beat until the beat carrying tlast is accepted, so packets are never interleaved. Sits in front of the shared header/payload FIFO pair; per-port enables let firmware quiesce individual requesters.

## Interface
- PORT_NUM, 4: number of requester ports (2..16).
- PORT_IDX_WIDTH, clog2(PORT_NUM): width of port index.
- TUSER_WIDTH, 128: header width per beat.
- TDATA_WIDTH, 256: payload width per beat.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cfg_port_en  in  PORT_NUM  per-port arbitration enable; sampled only at arbitration.
- s_tvalid  in  PORT_NUM  per-port valid.
- s_tlast  in  PORT_NUM  per-port last beat.
- s_tstart  in  PORT_NUM  per-port first beat (passed through).
- s_tuser  in  PORT_NUM*TUSER_WIDTH  port i at [i*TUSER_WIDTH +: TUSER_WIDTH].
- s_tdata  in  PORT_NUM*TDATA_WIDTH  port i at [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_tready  out  PORT_NUM  per-port ready.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output last.
- m_tstart  out  1  output start.
- m_tuser  out  TUSER_WIDTH  output header.
- m_tdata  out  TDATA_WIDTH  output payload.
- m_port_id  out  PORT_IDX_WIDTH  index of granted port.
- m_tready  in  1  downstream ready (stream FIFO axis_tready).

## Operation
- States: IDLE, LOCK (2-state FSM, registered).
- IDLE: request vector req = s_tvalid & cfg_port_en. If req != 0, select first set bit scanning from (last_grant+1) mod PORT_NUM upward with wrap; register grant, go to LOCK. If req == 0, stay IDLE.
- LOCK: m_* = combinational mux of granted port; s_tready[grant] = m_tready; all other s_tready = 0. Beat transfers when m_tvalid && m_tready.
- LOCK -> IDLE on transfer with m_tlast = 1; last_grant <= grant at that edge.
- cfg_port_en deassertion during LOCK does not abort the packet; takes effect at next IDLE.
- tstart not used for framing; passed through unchanged. Packet boundaries defined by tlast only.
- In IDLE: m_tvalid = 0, all s_tready = 0, m_tuser/m_tdata/m_tlast/m_tstart = 0 (zeroed when m_tvalid = 0, also in LOCK).
- Single-beat packet (tstart = tlast = 1) legal: one LOCK cycle if m_tready high.

## Timing
- Reset: state = IDLE, grant = 0, last_grant = PORT_NUM-1 (port 0 wins first), all outputs 0.
- Arbitration latency: request in IDLE at cycle N -> m_tvalid at cycle N+1 (one bubble per packet).
- Throughput within packet: one beat/cycle while source valid and m_tready high.
- Source valid drop mid-packet: m_tvalid = 0, grant held, no timeout.
- m_tready low: stall, grant held, s_tready[grant] low same cycle (combinational).
- Back-to-back packets same port, others idle: port regains grant after one IDLE cycle.
- Reset asserted mid-packet: immediate return to reset values; partial packet dropped; no recovery handshake.
- No combinational path from s_tvalid to s_tready (s_tready depends on state, grant, m_tready only).

## Structure
- Shared package: FSM state encoding (IDLE=0, LOCK=1), clog2 function for PORT_IDX_WIDTH.
- Sub-module rr_select: combinational rotate-priority picker (req, last_grant -> grant_idx, grant_valid), reusable by other arbiters.
- Top: FSM, grant/last_grant registers, output mux.

## Test plan
- Reset release, ports 0..3 each present one 1-beat packet simultaneously -> m_port_id sequence 0,1,2,3, one IDLE cycle between each.
- Port 2 sends 4-beat packet while port 1 raises valid at beat 2 -> all 4 port-2 beats contiguous, then port 1 granted; s_tready[1] = 0 throughout.
- m_tready toggles 1,0,1,0 during 3-beat packet from port 0 -> exactly 3 transfers, data order preserved, grant held.
- cfg_port_en = 4'b1011, ports 2 and 3 valid -> port 3 granted; port 2 never granted until enable restored.
- Reset asserted at beat 2 of 5-beat packet -> next cycle m_tvalid = 0, s_tready = 0; after release port 0 wins first.
- Port 3 last granted, ports 0 and 3 request -> port 0 granted (wrap-around).

Source files
------------

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-granular round-robin stream arbiter.
package stream_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_select.sv
// Rotate-priority picker: first set request bit scanning upward from the
// port after i_last_grant, wrapping at N.
module rr_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last_grant,
    output logic [W-1:0] o_grant_idx,
    output logic         o_grant_valid
);

    logic [W-1:0] w_cand;

    always_comb begin
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_cand        = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = W'((int'(i_last_grant) + k) % N);
            if (!o_grant_valid && i_req[w_cand]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Merges PORT_NUM request streams onto one output; a grant is held from the
// first accepted beat through the tlast beat so packets never interleave.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int PORT_NUM       = 4,
    parameter int PORT_IDX_WIDTH = clog2(PORT_NUM),
    parameter int TUSER_WIDTH    = 128,
    parameter int TDATA_WIDTH    = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORT_NUM-1:0]             cfg_port_en,
    input  logic [PORT_NUM-1:0]             s_tvalid,
    input  logic [PORT_NUM-1:0]             s_tlast,
    input  logic [PORT_NUM-1:0]             s_tstart,
    input  logic [PORT_NUM*TUSER_WIDTH-1:0] s_tuser,
    input  logic [PORT_NUM*TDATA_WIDTH-1:0] s_tdata,
    output logic [PORT_NUM-1:0]             s_tready,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    output logic                            m_tstart,
    output logic [TUSER_WIDTH-1:0]          m_tuser,
    output logic [TDATA_WIDTH-1:0]          m_tdata,
    output logic [PORT_IDX_WIDTH-1:0]       m_port_id,
    input  logic                            m_tready
);

    arb_state_t                r_state, w_state_nxt;
    logic [PORT_IDX_WIDTH-1:0] r_grant, w_grant_nxt;
    logic [PORT_IDX_WIDTH-1:0] r_last_grant, w_last_grant_nxt;
    logic [PORT_IDX_WIDTH-1:0] w_sel_idx;
    logic                      w_sel_vld;
    logic                      w_src_vld;
    logic [PORT_NUM-1:0]       w_req;

    assign w_req = s_tvalid & cfg_port_en;

    rr_select #(
        .N (PORT_NUM),
        .W (PORT_IDX_WIDTH)
    ) u_rr_select (
        .i_req         (w_req),
        .i_last_grant  (r_last_grant),
        .o_grant_idx   (w_sel_idx),
        .o_grant_valid (w_sel_vld)
    );

    // s_tready follows only state, grant and m_tready; payload is zeroed
    // whenever the granted source has nothing valid.
    always_comb begin
        w_src_vld = 1'b0;
        s_tready  = '0;
        m_tlast   = 1'b0;
        m_tstart  = 1'b0;
        m_tuser   = '0;
        m_tdata   = '0;
        if (r_state == ST_LOCK) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (r_grant == PORT_IDX_WIDTH'(i)) begin
                    s_tready[i] = m_tready;
                    w_src_vld   = s_tvalid[i];
                    if (s_tvalid[i]) begin
                        m_tlast  = s_tlast[i];
                        m_tstart = s_tstart[i];
                        m_tuser  = s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
                        m_tdata  = s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
                    end
                end
            end
        end
    end

    assign m_tvalid  = w_src_vld;
    assign m_port_id = r_grant;

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) begin
                    w_state_nxt = ST_LOCK;
                    w_grant_nxt = w_sel_idx;
                end
            end
            ST_LOCK: begin
                if (w_src_vld && m_tready && m_tlast) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // last_grant resets to the top port so port 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= PORT_IDX_WIDTH'(PORT_NUM - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized bench for stream_rr_arbiter against a packet-level arbitration model.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int TU = 16;
    localparam int TD = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    cfg_port_en;
    logic [N-1:0]    s_tvalid, s_tlast, s_tstart, s_tready;
    logic [N*TU-1:0] s_tuser;
    logic [N*TD-1:0] s_tdata;
    logic            m_tvalid, m_tlast, m_tstart, m_tready;
    logic [TU-1:0]   m_tuser;
    logic [TD-1:0]   m_tdata;
    logic [W-1:0]    m_port_id;

    stream_rr_arbiter #(
        .PORT_NUM       (N),
        .PORT_IDX_WIDTH (W),
        .TUSER_WIDTH    (TU),
        .TDATA_WIDTH    (TD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_port_en (cfg_port_en),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tstart    (s_tstart),
        .s_tuser     (s_tuser),
        .s_tdata     (s_tdata),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tstart    (m_tstart),
        .m_tuser     (m_tuser),
        .m_tdata     (m_tdata),
        .m_port_id   (m_port_id),
        .m_tready    (m_tready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source side: each port walks through packets, holding a beat until accepted.
    int            rem [N];
    logic          sv  [N];
    logic          sl  [N];
    logic          sst [N];
    logic [TU-1:0] su  [N];
    logic [TD-1:0] sd  [N];
    int            min_len, max_len, p_vld, p_rdy;
    logic [N-1:0]  en_mask;

    // Reference model: owner port (-1 when free) and last port that finished.
    int own;
    int last;
    int log_q[$];

    task automatic new_pkt(input int p);
        rem[p] = $urandom_range(max_len, min_len);
        sst[p] = 1'b1;
        sl[p]  = (rem[p] == 1);
        su[p]  = TU'($urandom);
        sd[p]  = TD'($urandom);
    endtask

    task automatic roll_vld(input int p);
        sv[p] = ($urandom_range(99, 0) < p_vld);
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            s_tvalid[p]           = sv[p];
            s_tlast[p]            = sl[p];
            s_tstart[p]           = sst[p];
            s_tuser[p*TU +: TU]   = su[p];
            s_tdata[p*TD +: TD]   = sd[p];
        end
        m_tready    = ($urandom_range(99, 0) < p_rdy);
        cfg_port_en = en_mask;
    endtask

    task automatic cycle();
        logic [N-1:0]  req, exp_rdy;
        logic          ev, el, es;
        logic [TU-1:0] eu;
        logic [TD-1:0] ed;
        drive();
        @(negedge clk);
        exp_rdy = '0; ev = 1'b0; el = 1'b0; es = 1'b0; eu = '0; ed = '0;
        if (own >= 0) begin
            ev = sv[own];
            exp_rdy[own] = m_tready;
            if (ev) begin
                el = sl[own]; es = sst[own]; eu = su[own]; ed = sd[own];
            end
        end
        chk("m_tvalid", 64'(m_tvalid), 64'(ev));
        chk("s_tready", 64'(s_tready), 64'(exp_rdy));
        chk("m_tuser",  64'(m_tuser),  64'(eu));
        chk("m_tdata",  64'(m_tdata),  64'(ed));
        chk("m_tlast",  64'(m_tlast),  64'(el));
        chk("m_tstart", 64'(m_tstart), 64'(es));
        if (ev) chk("m_port_id", 64'(m_port_id), 64'(own));
        if (m_tvalid && m_tready && m_tlast) log_q.push_back(int'(m_port_id));
        if (own < 0) begin
            for (int p = 0; p < N; p++) req[p] = sv[p] & en_mask[p];
            for (int k = 1; k <= N; k++)
                if (own < 0 && req[(last + k) % N]) own = (last + k) % N;
        end else if (ev && m_tready && sl[own]) begin
            last = own;
            own  = -1;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (sv[p] && exp_rdy[p]) begin
                if (sl[p]) begin
                    new_pkt(p);
                end else begin
                    rem[p]--;
                    sst[p] = 1'b0;
                    sl[p]  = (rem[p] == 1);
                    su[p]  = TU'($urandom);
                    sd[p]  = TD'($urandom);
                end
                roll_vld(p);
            end else if (!sv[p]) begin
                roll_vld(p);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_tvalid",  64'(m_tvalid),  64'd0);
        chk("rst_tready",  64'(s_tready),  64'd0);
        chk("rst_tuser",   64'(m_tuser),   64'd0);
        chk("rst_tdata",   64'(m_tdata),   64'd0);
        chk("rst_port_id", 64'(m_port_id), 64'd0);
        own  = -1;
        last = N - 1;
        for (int p = 0; p < N; p++) begin
            new_pkt(p);
            sv[p] = 1'b0;
        end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic all_valid();
        for (int p = 0; p < N; p++) sv[p] = 1'b1;
    endtask

    initial begin
        int n2;
        bit hit;
        rst = 1'b1; m_tready = 1'b0; cfg_port_en = '0;
        s_tvalid = '0; s_tlast = '0; s_tstart = '0; s_tuser = '0; s_tdata = '0;
        min_len = 1; max_len = 1; p_vld = 100; p_rdy = 100; en_mask = '1;
        #2;
        do_reset();

        // Every port offers a single-beat packet: grants rotate 0,1,2,3.
        all_valid();
        log_q.delete();
        repeat (12) cycle();
        for (int i = 0; i < 4; i++)
            chk("rr_seq", 64'((i < log_q.size()) ? log_q[i] : 99), 64'(i));

        // Port 2 disabled: it must never win while the mask holds.
        min_len = 1; max_len = 4; p_vld = 70; p_rdy = 80; en_mask = 4'b1011;
        log_q.delete();
        repeat (300) cycle();
        n2 = 0;
        foreach (log_q[i]) if (log_q[i] == 2) n2++;
        chk("en_block_p2", 64'(n2), 64'd0);

        // Mixed traffic with stalls, gaps and enable changes mid-packet.
        min_len = 1; max_len = 5; p_vld = 60; p_rdy = 60;
        for (int c = 0; c < 2000; c++) begin
            if (c % 25 == 0) en_mask = N'($urandom);
            cycle();
        end

        // Reset while beat 2 of a 5-beat packet is presented.
        en_mask = '1; min_len = 5; max_len = 5; p_vld = 100; p_rdy = 100;
        do_reset();
        all_valid();
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            cycle();
            if (own >= 0 && rem[own] == 4) hit = 1'b1;
        end
        chk("mid_pkt_reached", 64'(hit), 64'd1);
        do_reset();
        all_valid();
        log_q.delete();
        repeat (10) cycle();
        chk("first_after_rst", 64'((log_q.size() > 0) ? log_q[0] : 99), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
